// File: rtl/alu.sv
// alu: registered 32-bit MIPS-style ALU with multiply/divide and HI/LO next-value outputs.
module alu (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [5:0]  ALU_control,
    input  logic [4:0]  shiftAmount,
    input  logic [31:0] HI_IN,
    input  logic [31:0] LO_IN,
    output logic [31:0] aluResult,
    output logic [31:0] HI_OUT,
    output logic [31:0] LO_OUT
);
    logic [31:0] res, hi, lo;
    logic [31:0] sra_c, srav_c, sq, sr, uq, ur;
    logic [63:0] sp, up;
    logic        b_zero, div_ovf;

    assign sra_c   = $unsigned($signed(B) >>> shiftAmount);
    assign srav_c  = $unsigned($signed(B) >>> A[4:0]);
    assign sp      = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign up      = {32'b0, A} * {32'b0, B};
    assign b_zero  = B == 32'b0;
    // -2^31 / -1 overflows the quotient; pin it to the architected result
    assign div_ovf = A == 32'h8000_0000 && B == 32'hFFFF_FFFF;
    assign sq      = div_ovf ? 32'h8000_0000 : b_zero ? 32'b0 : $unsigned($signed(A) / $signed(B));
    assign sr      = div_ovf ? 32'b0 : b_zero ? 32'b0 : $unsigned($signed(A) % $signed(B));
    assign uq      = b_zero ? 32'b0 : A / B;
    assign ur      = b_zero ? 32'b0 : A % B;

    always_comb begin
        res = 32'b0;
        hi  = HI_IN;
        lo  = LO_IN;
        case (ALU_control)
            6'd0, 6'd1: res = A + B;
            6'd2, 6'd3: res = A - B;
            6'd4:  res = A & B;
            6'd5:  res = A | B;
            6'd6:  res = A ^ B;
            6'd7:  res = ~(A | B);
            6'd8:  res = {31'b0, $signed(A) < $signed(B)};
            6'd9:  res = {31'b0, A < B};
            6'd10: res = B << shiftAmount;
            6'd11: res = B >> shiftAmount;
            6'd12: res = sra_c;
            6'd13: res = B << A[4:0];
            6'd14: res = B >> A[4:0];
            6'd15: res = srav_c;
            6'd16: res = {B[15:0], 16'h0000};
            6'd17: {hi, lo} = sp;
            6'd18: {hi, lo} = up;
            6'd19: {hi, lo} = b_zero ? {HI_IN, LO_IN} : {sr, sq};
            6'd20: {hi, lo} = b_zero ? {HI_IN, LO_IN} : {ur, uq};
            6'd21: res = HI_IN;
            6'd22: res = LO_IN;
            6'd23: hi = A;
            6'd24: lo = A;
            6'd25: res = B;
            default: res = 32'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            aluResult <= 32'b0;
            HI_OUT    <= 32'b0;
            LO_OUT    <= 32'b0;
        end else begin
            aluResult <= res;
            HI_OUT    <= hi;
            LO_OUT    <= lo;
        end
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed scoreboard bench for the registered ALU.
module tb_alu;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] A = 32'b0, B = 32'b0, HI_IN = 32'b0, LO_IN = 32'b0;
    logic [5:0]  ALU_control = 6'd0;
    logic [4:0]  shiftAmount = 5'd0;
    logic [31:0] aluResult, HI_OUT, LO_OUT;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    alu dut (
        .CLK(CLK), .RESET(RESET), .A(A), .B(B), .ALU_control(ALU_control),
        .shiftAmount(shiftAmount), .HI_IN(HI_IN), .LO_IN(LO_IN),
        .aluResult(aluResult), .HI_OUT(HI_OUT), .LO_OUT(LO_OUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] hin,
                        input logic [31:0] lin, input logic [31:0] er, input logic [31:0] eh,
                        input logic [31:0] el);
        exp_t e;
        @(negedge CLK);
        ALU_control = op; A = a; B = b; shiftAmount = sh; HI_IN = hin; LO_IN = lin;
        e.tag = tag; e.res = er; e.hi = eh; e.lo = el;
        q.push_back(e);
        @(posedge CLK);
        #1;
        e = q.pop_front();
        check({e.tag, ".res"}, aluResult, e.res);
        check({e.tag, ".hi"}, HI_OUT, e.hi);
        check({e.tag, ".lo"}, LO_OUT, e.lo);
    endtask

    initial begin
        #1;
        check("por.res", aluResult, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        step("add_pre", 6'd0, 32'd5, 32'd7, 5'd0, 32'h11, 32'h22, 32'd12, 32'h11, 32'h22);
        // reset asserted between edges with nonzero inputs must clear outputs at once
        @(negedge CLK);
        ALU_control = 6'd0; A = 32'h100; B = 32'h200; HI_IN = 32'h33; LO_IN = 32'h44;
        #2 RESET = 1'b0;
        #1;
        check("rst_now.res", aluResult, 32'h0);
        check("rst_now.hi", HI_OUT, 32'h0);
        check("rst_now.lo", LO_OUT, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_hold.res", aluResult, 32'h0);
        check("rst_hold.hi", HI_OUT, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        step("add_5_7", 6'd0, 32'd5, 32'd7, 5'd0, 32'h0, 32'h0, 32'd12, 32'h0, 32'h0);
        #2 A = 32'hDEAD; B = 32'hBEEF;
        check("hold.res", aluResult, 32'd12);

        step("add_wrap", 6'd1, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h1, 32'h2, 32'h0, 32'h1, 32'h2);
        step("sub",      6'd2, 32'd3, 32'd5, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0, 32'h0);
        step("and",      6'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h0, 32'h0, 32'h00F0_1200, 32'h0, 32'h0);
        step("xor",      6'd6, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 32'h0, 32'h0, 32'h5555_5555, 32'h0, 32'h0);
        step("nor",      6'd7, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        step("slt",      6'd8, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 32'h0, 32'd1, 32'h0, 32'h0);
        step("sltu",     6'd9, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 32'h0, 32'd0, 32'h0, 32'h0);
        step("sll",      6'd10, 32'h0, 32'h0000_0003, 5'd30, 32'h0, 32'h0, 32'hC000_0000, 32'h0, 32'h0);
        step("sra",      6'd12, 32'h0, 32'h8000_0000, 5'd4, 32'h0, 32'h0, 32'hF800_0000, 32'h0, 32'h0);
        step("srlv",     6'd14, 32'h24, 32'h8000_0000, 5'd0, 32'h0, 32'h0, 32'h0800_0000, 32'h0, 32'h0);
        step("srav",     6'd15, 32'h3, 32'h8000_0010, 5'd9, 32'h0, 32'h0, 32'hF000_0002, 32'h0, 32'h0);
        step("lui",      6'd16, 32'h0, 32'h0000_1234, 5'd0, 32'h0, 32'h0, 32'h1234_0000, 32'h0, 32'h0);
        step("mult",     6'd17, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'h7, 32'h8, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        step("multu",    6'd18, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'h7, 32'h8, 32'h0, 32'h0000_0002, 32'hFFFF_FFFA);
        step("div",      6'd19, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        step("div_ovf",  6'd19, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h5, 32'h6, 32'h0, 32'h0, 32'h8000_0000);
        step("div_z",    6'd19, 32'd9, 32'd0, 5'd0, 32'hCC, 32'hDD, 32'h0, 32'hCC, 32'hDD);
        step("divu",     6'd20, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h7FFF_FFFC);
        step("divu_z",   6'd20, 32'd7, 32'd0, 5'd0, 32'hAA, 32'hBB, 32'h0, 32'hAA, 32'hBB);
        step("mfhi",     6'd21, 32'h1, 32'h2, 5'd0, 32'h77, 32'h99, 32'h77, 32'h77, 32'h99);
        step("mflo",     6'd22, 32'h1, 32'h2, 5'd0, 32'h77, 32'h99, 32'h99, 32'h77, 32'h99);
        step("mthi",     6'd23, 32'h55, 32'h2, 5'd0, 32'h10, 32'h20, 32'h0, 32'h55, 32'h20);
        step("mtlo",     6'd24, 32'h66, 32'h2, 5'd0, 32'h10, 32'h20, 32'h0, 32'h10, 32'h66);
        step("passb",    6'd25, 32'h1, 32'hCAFE_F00D, 5'd0, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0);
        step("op63",     6'd63, 32'h1234, 32'h5678, 5'd3, 32'h31, 32'h32, 32'h0, 32'h31, 32'h32);
        step("op26",     6'd26, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h41, 32'h42, 32'h0, 32'h41, 32'h42);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
